ccff_bitstream_loader: RTL and testbench

- Serialises configuration words onto the head of a configuration-chain (ccff) segment, such as a chain of fle/clb tiles.
- Accepts parallel bitstream words over a valid/ready handshake and shifts them MSB-first onto ccff_head, one bit per enabled cycle.
- Counts exactly CHAIN_LEN bits, then reports completion.
- Sits directly upstream of the tile ccff_head input, in the prog_clk domain.

---
 rtl/ccff_bitstream_loader.sv | 146 ++++++++++++++
 tb/tb_ccff_bitstream_loader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader
//   Streams parallel configuration words, MSB first, onto the head of a
//   configuration flip-flop chain (ccff) and stops after exactly CHAIN_LEN
//   bits. Runs in the prog_clk domain, directly upstream of the tile ccff_head.
//
// Ports
//   prog_clk       programming clock, all state updates on the rising edge
//   pReset         synchronous active-high reset
//   start          pulse: begin a load (only honoured in IDLE or DONE)
//   abort          synchronous abort of a load in progress
//   word_data      bitstream word, bit DATA_W-1 leaves first
//   word_valid     word_data is valid
//   word_ready     loader takes the word this cycle when word_valid is high
//   ccff_head      registered serial bit to the chain head
//   ccff_shift_en  registered, high in the cycles the chain must capture ccff_head
//   busy           load in progress (LOAD or SHIFT)
//   done           all CHAIN_LEN bits delivered, held until start/abort/reset
//   aborted        sticky flag, last load was aborted
//   bits_loaded    number of bits delivered in the current/last load
module ccff_bitstream_loader #(
   parameter int DATA_W    = 32,
   parameter int CHAIN_LEN = 20,
   parameter int CNT_W     = 16
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              start,
   input  logic              abort,
   input  logic [DATA_W-1:0] word_data,
   input  logic              word_valid,
   output logic              word_ready,
   output logic              ccff_head,
   output logic              ccff_shift_en,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic [CNT_W-1:0]  bits_loaded
);

   localparam int               RES_W    = $clog2(DATA_W + 1);
   localparam logic [RES_W-1:0] RES_FULL = RES_W'(DATA_W);
   localparam logic [RES_W-1:0] RES_ONE  = RES_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [DATA_W-1:0] sreg;
   logic [RES_W-1:0]  residual;
   logic              last_bit;
   logic              last_res;
   logic              accept;
   logic              start_load;

   // last_bit: the shift happening now delivers bit CHAIN_LEN.
   // last_res: the shift happening now empties the current word.
   assign last_bit   = (bits_loaded == CNT_LAST);
   assign last_res   = (residual == RES_ONE);
   assign accept     = word_ready && word_valid;
   assign start_load = start && !abort && ((state == ST_IDLE) || (state == ST_DONE));

   // State register
   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; abort takes precedence over everything but reset
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (start_load) state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            if (abort)           state_nxt = ST_IDLE;
            else if (word_valid) state_nxt = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (abort)                       state_nxt = ST_IDLE;
            else if (last_bit)               state_nxt = ST_DONE;
            else if (last_res && !word_valid) state_nxt = ST_LOAD;
         end
         ST_DONE: begin
            if (abort)           state_nxt = ST_IDLE;
            else if (start_load) state_nxt = ST_LOAD;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Status and handshake outputs. word_ready is also raised while the last
   // bit of a word is shifting out (prefetch) unless that bit ends the chain,
   // so a continuously valid source never opens a gap and never over-feeds.
   always_comb begin
      busy       = (state == ST_LOAD) || (state == ST_SHIFT);
      done       = (state == ST_DONE);
      word_ready = 1'b0;
      if (!pReset && !abort) begin
         if (state == ST_LOAD) begin
            word_ready = 1'b1;
         end else if ((state == ST_SHIFT) && last_res && !last_bit) begin
            word_ready = 1'b1;
         end
      end
   end

   // Shift datapath and counters. A prefetched word overrides the shift of
   // the emptied register in the same cycle.
   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         sreg          <= '0;
         residual      <= '0;
         ccff_head     <= 1'b0;
         ccff_shift_en <= 1'b0;
         bits_loaded   <= '0;
         aborted       <= 1'b0;
      end else begin
         ccff_shift_en <= 1'b0;
         if ((state == ST_SHIFT) && !abort) begin
            ccff_head     <= sreg[DATA_W-1];
            ccff_shift_en <= 1'b1;
            sreg          <= {sreg[DATA_W-2:0], 1'b0};
            residual      <= residual - RES_ONE;
            bits_loaded   <= bits_loaded + CNT_ONE;
         end
         if (accept) begin
            sreg     <= word_data;
            residual <= RES_FULL;
         end
         if (start_load) begin
            bits_loaded <= '0;
            aborted     <= 1'b0;
         end
         if (abort && busy) begin
            aborted <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: instance A (DATA_W=8, CHAIN_LEN=20) and
// instance B (DATA_W=8, CHAIN_LEN=8). A per-cycle model derives the expected
// serial stream from the source words, tracks a CHAIN_LEN-deep chain clocked
// by ccff_shift_en, and checks handshake/status rules; directed literals pin
// the model at the end of each scenario.
module tb_ccff_bitstream_loader;

   localparam int DW    = 8;
   localparam int LEN_A = 20;
   localparam int LEN_B = 8;
   localparam int CW    = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          a_rst, a_start, a_abort, a_valid;
   logic [DW-1:0] a_data;
   logic          a_ready, a_head, a_sen, a_busy, a_done, a_aborted;
   logic [CW-1:0] a_bl;
   logic          b_rst, b_start, b_abort, b_valid;
   logic [DW-1:0] b_data;
   logic          b_ready, b_head, b_sen, b_busy, b_done, b_aborted;
   logic [CW-1:0] b_bl;

   ccff_bitstream_loader #(.DATA_W(DW), .CHAIN_LEN(LEN_A), .CNT_W(CW)) dut_a (
      .prog_clk(clk), .pReset(a_rst), .start(a_start), .abort(a_abort),
      .word_data(a_data), .word_valid(a_valid), .word_ready(a_ready),
      .ccff_head(a_head), .ccff_shift_en(a_sen), .busy(a_busy), .done(a_done),
      .aborted(a_aborted), .bits_loaded(a_bl));

   ccff_bitstream_loader #(.DATA_W(DW), .CHAIN_LEN(LEN_B), .CNT_W(CW)) dut_b (
      .prog_clk(clk), .pReset(b_rst), .start(b_start), .abort(b_abort),
      .word_data(b_data), .word_valid(b_valid), .word_ready(b_ready),
      .ccff_head(b_head), .ccff_shift_en(b_sen), .busy(b_busy), .done(b_done),
      .aborted(b_aborted), .bits_loaded(b_bl));

   // Word sources and model state, index 0 = instance A, 1 = instance B
   logic [DW-1:0] src [2][8];
   int            idx [2];
   int            cnt [2];
   logic          en  [2];
   int            len [2];
   int            n [2], acc [2], sen_tot [2], run_cur [2], run_max [2], under [2];
   int            first_sen [2], start_cyc [2];
   logic [31:0]   chain [2];
   logic          prev_head [2], rst_prev [2];
   logic          s_head [2], s_sen [2], s_rdy [2], s_busy [2], s_done [2], s_abt [2];
   int            s_bl [2];
   logic          i_rst [2], i_start [2], i_abort [2], i_valid [2];
   int            cyc;
   int            n_cmp, n_fail;

   task automatic chk(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Bit i of the stream is bit (7 - i%8) of source word i/8
   function automatic int exp_bit(input int k, input int i);
      logic [DW-1:0] w;
      if (i < 0 || i >= 64) return 0;
      w = src[k][i / DW];
      return int'(w[DW - 1 - (i % DW)]);
   endfunction

   task automatic drive_src();
      a_data  = src[0][idx[0] % 8];
      a_valid = en[0] && (idx[0] < cnt[0]);
      b_data  = src[1][idx[1] % 8];
      b_valid = en[1] && (idx[1] < cnt[1]);
   endtask

   task automatic sample();
      s_head[0] = a_head; s_sen[0] = a_sen; s_rdy[0] = a_ready; s_busy[0] = a_busy;
      s_done[0] = a_done; s_abt[0] = a_aborted; s_bl[0] = int'(a_bl);
      i_rst[0] = a_rst; i_start[0] = a_start; i_abort[0] = a_abort; i_valid[0] = a_valid;
      s_head[1] = b_head; s_sen[1] = b_sen; s_rdy[1] = b_ready; s_busy[1] = b_busy;
      s_done[1] = b_done; s_abt[1] = b_aborted; s_bl[1] = int'(b_bl);
      i_rst[1] = b_rst; i_start[1] = b_start; i_abort[1] = b_abort; i_valid[1] = b_valid;
   endtask

   task automatic check_dut(input int k);
      int need;
      need = (len[k] + DW - 1) / DW;
      if (cyc > 0) begin
         if (rst_prev[k]) begin
            chk("reset_outputs", int'({s_head[k], s_sen[k], s_rdy[k], s_busy[k], s_done[k], s_abt[k]}), 0);
            chk("reset_bits_loaded", s_bl[k], 0);
         end else begin
            chk("ready_only_when_busy", int'(s_rdy[k] && !s_busy[k]), 0);
            chk("busy_done_exclusive", int'(s_busy[k] && s_done[k]), 0);
            if (s_sen[k]) begin
               chk("head_bit", int'(s_head[k]), exp_bit(k, n[k]));
               n[k]++;
               chain[k] = {chain[k][30:0], s_head[k]};
               sen_tot[k]++;
               run_cur[k]++;
               if (run_cur[k] > run_max[k]) run_max[k] = run_cur[k];
               if (first_sen[k] < 0) first_sen[k] = cyc;
            end else begin
               chk("head_hold", int'(s_head[k]), int'(prev_head[k]));
               run_cur[k] = 0;
               if (s_busy[k] && s_rdy[k]) under[k]++;
            end
            chk("bits_loaded", s_bl[k], n[k]);
            if (s_done[k]) chk("done_count", s_bl[k], len[k]);
         end
         if (i_rst[k]) chk("ready_in_reset", int'(s_rdy[k]), 0);
      end
      // Model update for the coming edge
      if (i_valid[k] && s_rdy[k] && !i_rst[k]) begin
         acc[k]++;
         chk("word_budget", int'(acc[k] <= need), 1);
      end
      if (i_rst[k]) begin
         n[k] = 0;
      end else if (i_start[k] && !i_abort[k] && !s_busy[k]) begin
         n[k] = 0; acc[k] = 0; sen_tot[k] = 0; run_cur[k] = 0; run_max[k] = 0;
         under[k] = 0; first_sen[k] = -1; start_cyc[k] = cyc;
      end
      prev_head[k] = s_head[k];
      rst_prev[k]  = i_rst[k];
   endtask

   // One clock: inputs settle at negedge, sample 1 time unit before posedge
   task automatic step();
      logic f0, f1;
      drive_src();
      #4;
      sample();
      check_dut(0);
      check_dut(1);
      f0 = i_valid[0] && s_rdy[0] && !i_rst[0];
      f1 = i_valid[1] && s_rdy[1] && !i_rst[1];
      @(posedge clk);
      #1;
      if (f0) idx[0]++;
      if (f1) idx[1]++;
      cyc++;
      drive_src();
      @(negedge clk);
   endtask

   task automatic run_until_done(input int k, input int budget);
      step();
      for (int i = 0; i < budget; i++) begin
         if (s_done[k]) break;
         step();
      end
   endtask

   initial begin
      n_cmp = 0; n_fail = 0; cyc = 0;
      len = '{LEN_A, LEN_B};
      for (int k = 0; k < 2; k++) begin
         idx[k] = 0; cnt[k] = 0; en[k] = 1'b0; n[k] = 0; acc[k] = 0;
         sen_tot[k] = 0; run_cur[k] = 0; run_max[k] = 0; under[k] = 0;
         first_sen[k] = -1; start_cyc[k] = 0; chain[k] = '0;
         prev_head[k] = 1'b0; rst_prev[k] = 1'b0;
         for (int j = 0; j < 8; j++) src[k][j] = '0;
      end
      src[0][0] = 8'hA5; src[0][1] = 8'h3C; src[0][2] = 8'hF0; src[0][3] = 8'h77;
      cnt[0] = 4;
      src[1][0] = 8'h5A; src[1][1] = 8'h99;
      cnt[1] = 2;
      a_rst = 1'b1; a_start = 1'b0; a_abort = 1'b0;
      b_rst = 1'b1; b_start = 1'b0; b_abort = 1'b0;
      drive_src();
      step(); step();
      a_rst = 1'b0; b_rst = 1'b0;
      step(); step();
      chk("idle_busy", int'(s_busy[0]), 0);

      // Scenario 1: continuous source, 20 bits from A5 3C F0
      idx[0] = 0; en[0] = 1'b1;
      a_start = 1'b1; step(); a_start = 1'b0;
      run_until_done(0, 60);
      chk("s1_done", int'(s_done[0]), 1);
      chk("s1_bits", s_bl[0], 20);
      chk("s1_words", acc[0], 3);
      chk("s1_chain", int'(chain[0][19:0]), int'(20'hA53CF));
      chk("s1_tail_is_first_bit", int'(chain[0][19]), 1);
      chk("s1_run", run_max[0], 20);
      chk("s1_underrun", under[0], 1);
      // enable rises on the second edge after the edge that registered start
      chk("s1_latency", first_sen[0] - start_cyc[0] - 1, 2);
      step(); step(); step();
      chk("s1_done_held", int'(s_done[0]), 1);
      chk("s1_no_extra_word", idx[0], 3);

      // Scenario 2: source drops out after the first word
      idx[0] = 0;
      a_start = 1'b1; step(); a_start = 1'b0;
      repeat (6) step();
      en[0] = 1'b0;
      repeat (8) step();
      en[0] = 1'b1;
      run_until_done(0, 60);
      chk("s2_done", int'(s_done[0]), 1);
      chk("s2_total_enables", sen_tot[0], 20);
      chk("s2_run", run_max[0], 12);
      chk("s2_underrun", under[0], 6);
      chk("s2_chain", int'(chain[0][19:0]), int'(20'hA53CF));
      chk("s2_words", acc[0], 3);

      // Scenario 3: abort after 11 bits, then restart
      idx[0] = 0;
      a_start = 1'b1; step(); a_start = 1'b0;
      for (int i = 0; i < 60 && n[0] < 10; i++) step();
      a_abort = 1'b1; step(); a_abort = 1'b0; step();
      chk("s3_idle", int'(s_busy[0]), 0);
      chk("s3_aborted", int'(s_abt[0]), 1);
      chk("s3_bits", s_bl[0], 11);
      chk("s3_sen", int'(s_sen[0]), 0);
      idx[0] = 0;
      a_start = 1'b1; step(); a_start = 1'b0; step();
      chk("s3_aborted_cleared", int'(s_abt[0]), 0);
      chk("s3_restart_bits", s_bl[0], 0);
      chk("s3_restart_busy", int'(s_busy[0]), 1);
      run_until_done(0, 60);
      chk("s3_chain", int'(chain[0][19:0]), int'(20'hA53CF));
      chk("s3_bits_final", s_bl[0], 20);
      a_abort = 1'b1; step(); a_abort = 1'b0; step();
      chk("s3_abort_in_done", int'({s_done[0], s_busy[0], s_abt[0]}), 0);
      a_start = 1'b1; a_abort = 1'b1; step(); a_start = 1'b0; a_abort = 1'b0; step();
      chk("s3_abort_beats_start", int'(s_busy[0]), 0);

      // Scenario 4: reset mid-shift, start coincident with release
      idx[0] = 0;
      a_start = 1'b1; step(); a_start = 1'b0;
      for (int i = 0; i < 60 && n[0] < 5; i++) step();
      a_rst = 1'b1; step(); step();
      chk("s4_reset_bits", s_bl[0], 0);
      a_start = 1'b1; step();
      idx[0] = 0;
      a_rst = 1'b0; step();
      chk("s4_start_in_reset_ignored", int'(s_busy[0]), 0);
      a_start = 1'b0; step();
      chk("s4_start_on_release", int'(s_busy[0]), 1);
      run_until_done(0, 60);
      chk("s4_chain", int'(chain[0][19:0]), int'(20'hA53CF));
      chk("s4_words", acc[0], 3);

      // Scenario 5: exact fit on B, start while busy, repeated load
      idx[1] = 0; en[1] = 1'b1;
      b_start = 1'b1; step(); b_start = 1'b0;
      step(); step();
      b_start = 1'b1; step(); b_start = 1'b0;
      run_until_done(1, 40);
      chk("s5_done", int'(s_done[1]), 1);
      chk("s5_words", acc[1], 1);
      chk("s5_src_index", idx[1], 1);
      chk("s5_chain", int'(chain[1][7:0]), int'(8'h5A));
      chk("s5_run", run_max[1], 8);
      idx[1] = 0;
      b_start = 1'b1; step(); b_start = 1'b0;
      run_until_done(1, 40);
      chk("s5_done_2", int'(s_done[1]), 1);
      chk("s5_words_2", acc[1], 1);
      chk("s5_chain_2", int'(chain[1][7:0]), int'(8'h5A));
      chk("s5_bits_2", s_bl[1], 8);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
